riscv_core_icache_ctrl_2way: RTL

Second-generation instruction-cache controller: 2-way set-associative with per-set LRU replacement. Geometry is parametrised, and a 32-bit instruction that straddles a line boundary is handled. Adds a whole-cache flush, memory error reporting and a latched miss context. Sits between the fetch stage, the icache data array (driven via rd/wr/way/offset strobes) and the AXI refill engine.

---
 rtl/riscv_icache_pkg.sv | 19 +
 rtl/riscv_core_icache_tag_array.sv | 87 ++++++++
 rtl/riscv_core_icache_ctrl_2way.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/riscv_icache_pkg.sv
// rtl/riscv_icache_pkg.sv - shared state type and geometry helpers for the 2-way icache controller
package riscv_icache_pkg;

  typedef enum logic [2:0] {LOOKUP, MISS_WAIT, REFILL, ERR, FLUSH} state_e;

  function automatic int calc_offset_width(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int calc_tag_width(input int addr_width, input int index_width,
                                        input int line_bytes);
    return addr_width - index_width - $clog2(line_bytes);
  endfunction

  function automatic logic [63:0] line_align(input logic [63:0] addr, input int offset_width);
    return addr & ~((64'd1 << offset_width) - 64'd1);
  endfunction

endpackage

// File: rtl/riscv_core_icache_tag_array.sv
// rtl/riscv_core_icache_tag_array.sv - 2-way tag/valid store with per-set LRU bit
// Two combinational lookup ports (line of addr, line of addr+2), one refill write port, one per-set clear.
module riscv_core_icache_tag_array #(
  parameter int INDEX_WIDTH = 7,
  parameter int TAG_WIDTH   = 52
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INDEX_WIDTH-1:0] a_set,
  input  logic [TAG_WIDTH-1:0]   a_tag,
  output logic                   a_hit,
  output logic                   a_way,
  output logic [1:0]             a_valid,
  output logic                   a_lru,
  input  logic [INDEX_WIDTH-1:0] b_set,
  input  logic [TAG_WIDTH-1:0]   b_tag,
  output logic                   b_hit,
  output logic                   b_way,
  output logic [1:0]             b_valid,
  output logic                   b_lru,
  input  logic                   touch_en,
  input  logic                   touch_b,
  input  logic                   wr_en,
  input  logic                   wr_way,
  input  logic [INDEX_WIDTH-1:0] wr_set,
  input  logic [TAG_WIDTH-1:0]   wr_tag,
  input  logic                   clr_en,
  input  logic [INDEX_WIDTH-1:0] clr_set
);

  localparam int DEPTH = 2**INDEX_WIDTH;

  logic [TAG_WIDTH-1:0] tag_q [DEPTH][2];
  logic [TAG_WIDTH-1:0] tag_d [DEPTH][2];
  logic [1:0]           valid_q [DEPTH];
  logic [1:0]           valid_d [DEPTH];
  logic [DEPTH-1:0]     lru_q, lru_d;
  logic [1:0]           a_h, b_h;

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      a_h[w] = valid_q[a_set][w] && (tag_q[a_set][w] == a_tag);
      b_h[w] = valid_q[b_set][w] && (tag_q[b_set][w] == b_tag);
    end
  end

  assign a_hit   = |a_h;
  assign a_way   = ~a_h[0];
  assign a_valid = valid_q[a_set];
  assign a_lru   = lru_q[a_set];
  assign b_hit   = |b_h;
  assign b_way   = ~b_h[0];
  assign b_valid = valid_q[b_set];
  assign b_lru   = lru_q[b_set];

  // LRU bit names the way to evict next, so a use points it at the other way
  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    lru_d   = lru_q;
    if (touch_en) begin
      lru_d[a_set] = ~a_way;
      if (touch_b) lru_d[b_set] = ~b_way;
    end
    if (wr_en) begin
      tag_d[wr_set][wr_way]   = wr_tag;
      valid_d[wr_set][wr_way] = 1'b1;
      lru_d[wr_set]           = ~wr_way;
    end
    if (clr_en) begin
      valid_d[clr_set] = 2'b00;
      lru_d[clr_set]   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    if (rst) begin
      valid_q <= '{default: '0};
      lru_q   <= '0;
    end else begin
      valid_q <= valid_d;
      lru_q   <= lru_d;
    end
  end

endmodule

// File: rtl/riscv_core_icache_ctrl_2way.sv
// rtl/riscv_core_icache_ctrl_2way.sv - 2-way set-associative icache controller with line-crossing fetch,
// whole-cache flush and refill error reporting.
module riscv_core_icache_ctrl_2way
  import riscv_icache_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int LINE_BYTES  = 32,
  parameter int INDEX_WIDTH = 7
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_addr_from_core,
  input  logic                  i_req_valid,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_rd_en,
  output logic                  o_rd_way,
  output logic                  o_rd_way_next,
  output logic                  o_wr_en,
  output logic                  o_wr_way,
  output logic                  o_offset,
  output logic [ADDR_WIDTH-1:0] o_addr_from_control_to_axi,
  output logic                  o_mem_req,
  input  logic                  i_mem_done,
  input  logic                  i_mem_err,
  output logic                  o_fetch_err,
  output logic                  o_flush_busy
);

  localparam int OFFSET_WIDTH = calc_offset_width(LINE_BYTES);
  localparam int TAG_WIDTH    = calc_tag_width(ADDR_WIDTH, INDEX_WIDTH, LINE_BYTES);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   miss_addr_q, miss_addr_d;
  logic                    miss_off_q, miss_off_d;
  logic                    miss_way_q, miss_way_d;
  logic                    flush_pending_q, flush_pending_d;
  logic [INDEX_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;

  logic [ADDR_WIDTH-1:0]   addr_next;
  logic                    crossing;
  logic                    a_hit, a_way, a_lru, b_hit, b_way, b_lru;
  logic [1:0]              a_valid, b_valid;
  logic                    s1, s2, victim_a, victim_b;
  logic                    touch_en, tag_wr_en, clr_en;

  assign addr_next = i_addr_from_core + ADDR_WIDTH'(2);
  assign crossing  = i_addr_from_core[OFFSET_WIDTH-1:0] == OFFSET_WIDTH'(LINE_BYTES - 2);
  assign s1        = ~a_hit;
  assign s2        = crossing & ~b_hit;
  assign victim_a  = ~a_valid[0] ? 1'b0 : (~a_valid[1] ? 1'b1 : a_lru);
  assign victim_b  = ~b_valid[0] ? 1'b0 : (~b_valid[1] ? 1'b1 : b_lru);

  riscv_core_icache_tag_array #(
    .INDEX_WIDTH(INDEX_WIDTH),
    .TAG_WIDTH  (TAG_WIDTH)
  ) u_tag_array (
    .clk     (i_clk),
    .rst     (i_rst),
    .a_set   (i_addr_from_core[OFFSET_WIDTH +: INDEX_WIDTH]),
    .a_tag   (i_addr_from_core[ADDR_WIDTH-1 -: TAG_WIDTH]),
    .a_hit   (a_hit),
    .a_way   (a_way),
    .a_valid (a_valid),
    .a_lru   (a_lru),
    .b_set   (addr_next[OFFSET_WIDTH +: INDEX_WIDTH]),
    .b_tag   (addr_next[ADDR_WIDTH-1 -: TAG_WIDTH]),
    .b_hit   (b_hit),
    .b_way   (b_way),
    .b_valid (b_valid),
    .b_lru   (b_lru),
    .touch_en(touch_en),
    .touch_b (crossing),
    .wr_en   (tag_wr_en),
    .wr_way  (miss_way_q),
    .wr_set  (miss_addr_q[OFFSET_WIDTH +: INDEX_WIDTH]),
    .wr_tag  (miss_addr_q[ADDR_WIDTH-1 -: TAG_WIDTH]),
    .clr_en  (clr_en),
    .clr_set (flush_cnt_q)
  );

  always_comb begin
    state_d         = state_q;
    miss_addr_d     = miss_addr_q;
    miss_off_d      = miss_off_q;
    miss_way_d      = miss_way_q;
    flush_pending_d = flush_pending_q;
    flush_cnt_d     = flush_cnt_q;
    o_stall         = 1'b0;
    o_rd_en         = 1'b0;
    o_rd_way        = 1'b0;
    o_rd_way_next   = 1'b0;
    o_wr_en         = 1'b0;
    o_wr_way        = 1'b0;
    o_offset        = 1'b0;
    o_addr_from_control_to_axi = '0;
    o_mem_req       = 1'b0;
    o_fetch_err     = 1'b0;
    o_flush_busy    = 1'b0;
    touch_en        = 1'b0;
    tag_wr_en       = 1'b0;
    clr_en          = 1'b0;

    case (state_q)
      LOOKUP: begin
        if (i_flush) begin
          o_stall     = 1'b1;
          flush_cnt_d = '0;
          state_d     = FLUSH;
        end else if (i_req_valid) begin
          if (!s1 && !s2) begin
            o_rd_en       = 1'b1;
            o_rd_way      = a_way;
            o_rd_way_next = crossing & b_way;
            touch_en      = 1'b1;
          end else begin
            // first line is always refilled first; the second miss resurfaces on re-lookup
            miss_addr_d = s1 ? ADDR_WIDTH'(line_align(64'(i_addr_from_core), OFFSET_WIDTH))
                             : ADDR_WIDTH'(line_align(64'(addr_next), OFFSET_WIDTH));
            miss_off_d  = ~s1;
            miss_way_d  = s1 ? victim_a : victim_b;
            o_stall     = 1'b1;
            o_mem_req   = 1'b1;
            o_addr_from_control_to_axi = miss_addr_d;
            state_d     = MISS_WAIT;
          end
        end
      end
      MISS_WAIT: begin
        o_stall   = 1'b1;
        o_mem_req = 1'b1;
        o_addr_from_control_to_axi = miss_addr_q;
        if (i_flush) flush_pending_d = 1'b1;
        if (i_mem_done) state_d = i_mem_err ? ERR : REFILL;
      end
      REFILL: begin
        o_stall   = 1'b1;
        o_wr_en   = 1'b1;
        o_wr_way  = miss_way_q;
        o_offset  = miss_off_q;
        o_addr_from_control_to_axi = miss_addr_q;
        tag_wr_en = 1'b1;
        flush_cnt_d     = '0;
        flush_pending_d = 1'b0;
        state_d         = flush_pending_q ? FLUSH : LOOKUP;
      end
      ERR: begin
        o_fetch_err     = 1'b1;
        flush_cnt_d     = '0;
        flush_pending_d = 1'b0;
        state_d         = flush_pending_q ? FLUSH : LOOKUP;
      end
      FLUSH: begin
        o_stall      = 1'b1;
        o_flush_busy = 1'b1;
        clr_en       = 1'b1;
        flush_cnt_d  = flush_cnt_q + 1'b1;
        if (&flush_cnt_q) state_d = LOOKUP;
      end
      default: state_d = LOOKUP;
    endcase

    if (i_rst) begin
      o_stall       = 1'b0;
      o_rd_en       = 1'b0;
      o_rd_way      = 1'b0;
      o_rd_way_next = 1'b0;
      o_wr_en       = 1'b0;
      o_wr_way      = 1'b0;
      o_offset      = 1'b0;
      o_addr_from_control_to_axi = '0;
      o_mem_req     = 1'b0;
      o_fetch_err   = 1'b0;
      o_flush_busy  = 1'b0;
      touch_en      = 1'b0;
      tag_wr_en     = 1'b0;
      clr_en        = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q         <= LOOKUP;
      miss_addr_q     <= '0;
      miss_off_q      <= 1'b0;
      miss_way_q      <= 1'b0;
      flush_pending_q <= 1'b0;
      flush_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      miss_addr_q     <= miss_addr_d;
      miss_off_q      <= miss_off_d;
      miss_way_q      <= miss_way_d;
      flush_pending_q <= flush_pending_d;
      flush_cnt_q     <= flush_cnt_d;
    end
  end

endmodule
